// File: rtl/enc_16x4_pend_pkg.sv
// Shared constants, state type and helpers
// for the 16-to-4 pending encoder.
package enc_pkg;

  localparam int N_DEF = 16;
  localparam int W_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [N_DEF-1:0] onehot(
    input logic [W_DEF-1:0] idx
  );
    logic [N_DEF-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/enc_16x4_pend_if.sv
// Index output handshake between the encoder
// and its consumer.
interface enc_16x4_pend_if #(
  parameter int W = 4
);

  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/enc_16x4_pend_prio_sel.sv
// Rotating lowest-set-bit search: first set
// index at or above s, wrapping modulo N.
module prio_sel #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] v,
  input  logic [W-1:0] s,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] rot;
  logic [W-1:0] j;
  logic [W-1:0] k;

  always_comb begin
    rot = '0;
    j   = '0;
    for (int i = 0; i < N; i++) begin
      j      = W'(i) + s;
      rot[i] = v[j];
    end
  end

  always_comb begin
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) k = W'(i);
    end
  end

  assign idx   = k + s;
  assign found = |v;

endmodule

// File: rtl/enc_16x4_pend.sv
// Sticky multi-hot request collector that hands
// out one index per valid/ready transfer.
module enc_16x4_pend
  import enc_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter bit RR = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] in,
  output logic [N-1:0] pending,
  output logic         ovf,
  enc_16x4_pend_if.master o
);

  state_e       state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] pend_q, pend_d;
  logic         ovf_q, ovf_d;

  logic         xfer;
  logic [N-1:0] req;
  logic [N-1:0] hot;
  logic [N-1:0] clr;
  logic [N-1:0] rem;
  logic [N-1:0] sv;
  logic [W-1:0] ss;
  logic [W-1:0] sidx;
  logic         sfound;

  assign xfer = (state_q == HOLD) && o.out_ready;
  assign req  = en ? in : '0;
  assign hot  = onehot(out_q);
  assign clr  = xfer ? hot : '0;
  // rem never sees same-cycle requests
  assign rem  = pend_q & ~hot;

  assign pend_d = (pend_q & ~clr) | req;
  assign ovf_d  = ovf_q | (|(req & pend_q & ~clr));

  // Start just past the index being accepted now,
  // otherwise just past the last accepted one.
  assign sv = (state_q == HOLD) ? rem : pend_q;
  assign ss = !RR ? '0 :
              xfer ? out_q + 1'b1 :
              ptr_q + 1'b1;

  prio_sel #(
    .N (N),
    .W (W)
  ) u_sel (
    .v     (sv),
    .s     (ss),
    .idx   (sidx),
    .found (sfound)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      ptr_q   <= W'(N - 1);
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (sfound) begin
          out_d   = sidx;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (xfer) begin
          ptr_d = out_q;
          if (sfound) out_d   = sidx;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o.out_valid = (state_q == HOLD);
    o.out       = out_q;
    pending     = pend_q;
    ovf         = ovf_q;
  end

endmodule

// File: tb/tb_enc_16x4_pend.sv
// Directed bench: fixed-priority and round-robin
// encoders driven by the same stimulus.
module tb_enc_16x4_pend;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic        rdy;
  logic [15:0] pend0, pend1;
  logic        ovf0, ovf1;
  int          tests;
  int          failed;

  enc_16x4_pend_if #(.W(4)) if0 ();
  enc_16x4_pend_if #(.W(4)) if1 ();

  assign if0.out_ready = rdy;
  assign if1.out_ready = rdy;

  enc_16x4_pend #(.N(16), .W(4), .RR(1'b0)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (req),
    .pending (pend0),
    .ovf     (ovf0),
    .o       (if0.master)
  );

  enc_16x4_pend #(.N(16), .W(4), .RR(1'b1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (req),
    .pending (pend1),
    .ovf     (ovf1),
    .o       (if1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req = '0; rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tests++; if (if0.out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid0 got %b exp 0", if0.out_valid); end
    tests++; if (if1.out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid1 got %b exp 0", if1.out_valid); end
    tests++; if (if0.out !== 4'd0) begin failed++; $display("FAIL reset_out0 got %0d exp 0", if0.out); end
    tests++; if (pend0 !== 16'h0) begin failed++; $display("FAIL reset_pend0 got %h exp 0000", pend0); end
    tests++; if (ovf0 !== 1'b0) begin failed++; $display("FAIL reset_ovf0 got %b exp 0", ovf0); end
  endtask

  task automatic test_zero_req();
    en = 1'b1; req = 16'h0000; rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (if0.out_valid !== 1'b0 || if0.out !== 4'd0) begin failed++; $display("FAIL zero_out c%0d got v=%b o=%0d exp v=0 o=0", i, if0.out_valid, if0.out); end
      tests++; if (pend0 !== 16'h0 || ovf0 !== 1'b0) begin failed++; $display("FAIL zero_pend c%0d got p=%h f=%b exp p=0000 f=0", i, pend0, ovf0); end
    end
  endtask

  task automatic test_en_low();
    en = 1'b0; req = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (pend0 !== 16'h0 || if0.out_valid !== 1'b0) begin failed++; $display("FAIL en_low c%0d got p=%h v=%b exp p=0000 v=0", i, pend0, if0.out_valid); end
    end
    req = '0;
  endtask

  task automatic test_burst();
    logic [3:0] exp_o [4];
    logic [15:0] exp_p [4];
    exp_o = '{4'd0, 4'd5, 4'd10, 4'd15};
    exp_p = '{16'h8421, 16'h8420, 16'h8400, 16'h8000};
    en = 1'b1; req = 16'h8421; rdy = 1'b1;
    tick();
    en = 1'b0; req = '0;
    tests++; if (if0.out_valid !== 1'b0 || pend0 !== 16'h8421) begin failed++; $display("FAIL burst_capture got v=%b p=%h exp v=0 p=8421", if0.out_valid, pend0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (if0.out_valid !== 1'b1 || if0.out !== exp_o[i]) begin failed++; $display("FAIL burst_fix%0d got v=%b o=%0d exp v=1 o=%0d", i, if0.out_valid, if0.out, exp_o[i]); end
      tests++; if (if1.out_valid !== 1'b1 || if1.out !== exp_o[i]) begin failed++; $display("FAIL burst_rr%0d got v=%b o=%0d exp v=1 o=%0d", i, if1.out_valid, if1.out, exp_o[i]); end
      tests++; if (pend0 !== exp_p[i]) begin failed++; $display("FAIL burst_pend%0d got %h exp %h", i, pend0, exp_p[i]); end
    end
    tick();
    tests++; if (if0.out_valid !== 1'b0 || pend0 !== 16'h0) begin failed++; $display("FAIL burst_end got v=%b p=%h exp v=0 p=0000", if0.out_valid, pend0); end
  endtask

  task automatic test_set_over_clear();
    en = 1'b1; req = 16'h0004; rdy = 1'b0;
    tick();
    en = 1'b0; req = '0;
    tick();
    tests++; if (if0.out_valid !== 1'b1 || if0.out !== 4'd2) begin failed++; $display("FAIL soc_hold got v=%b o=%0d exp v=1 o=2", if0.out_valid, if0.out); end
    en = 1'b1; req = 16'h0004; rdy = 1'b1;
    tick();
    en = 1'b0; req = '0;
    tests++; if (if0.out_valid !== 1'b0 || pend0 !== 16'h0004 || ovf0 !== 1'b0) begin failed++; $display("FAIL soc_rereq got v=%b p=%h f=%b exp v=0 p=0004 f=0", if0.out_valid, pend0, ovf0); end
    tick();
    tests++; if (if0.out_valid !== 1'b1 || if0.out !== 4'd2) begin failed++; $display("FAIL soc_reload got v=%b o=%0d exp v=1 o=2", if0.out_valid, if0.out); end
    tick();
    tests++; if (if0.out_valid !== 1'b0 || pend0 !== 16'h0) begin failed++; $display("FAIL soc_done got v=%b p=%h exp v=0 p=0000", if0.out_valid, pend0); end
  endtask

  task automatic test_backpressure();
    en = 1'b1; req = 16'h0010; rdy = 1'b0;
    tick();
    en = 1'b0; req = '0;
    tick();
    tests++; if (if0.out_valid !== 1'b1 || if0.out !== 4'd4) begin failed++; $display("FAIL bp_load got v=%b o=%0d exp v=1 o=4", if0.out_valid, if0.out); end
    en = 1'b1; req = 16'h0001;
    tick();
    tests++; if (if0.out !== 4'd4 || pend0 !== 16'h0011) begin failed++; $display("FAIL bp_lowreq got o=%0d p=%h exp o=4 p=0011", if0.out, pend0); end
    tests++; if (ovf0 !== 1'b0) begin failed++; $display("FAIL bp_noovf got %b exp 0", ovf0); end
    req = 16'h0010;
    tick();
    en = 1'b0; req = '0;
    tests++; if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || pend0 !== 16'h0011) begin failed++; $display("FAIL bp_ovf got f0=%b f1=%b p=%h exp 1 1 0011", ovf0, ovf1, pend0); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (if0.out_valid !== 1'b1 || if0.out !== 4'd4) begin failed++; $display("FAIL bp_stall%0d got v=%b o=%0d exp v=1 o=4", i, if0.out_valid, if0.out); end
    end
    rdy = 1'b1;
    tick();
    tests++; if (if0.out !== 4'd0 || if1.out !== 4'd0 || pend0 !== 16'h0001) begin failed++; $display("FAIL bp_next got o0=%0d o1=%0d p=%h exp 0 0 0001", if0.out, if1.out, pend0); end
    tick();
    tests++; if (if0.out_valid !== 1'b0 || pend0 !== 16'h0 || ovf0 !== 1'b1) begin failed++; $display("FAIL bp_end got v=%b p=%h f=%b exp v=0 p=0000 f=1", if0.out_valid, pend0, ovf0); end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; req = 16'h00F0; rdy = 1'b0;
    tick();
    en = 1'b0; req = '0;
    tick();
    tests++; if (if0.out_valid !== 1'b1 || if0.out !== 4'd4 || pend0 !== 16'h00F0) begin failed++; $display("FAIL rmid_pre got v=%b o=%0d p=%h exp v=1 o=4 p=00f0", if0.out_valid, if0.out, pend0); end
    rst = 1'b1; en = 1'b1; req = 16'h0F00; rdy = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; req = '0; rdy = 1'b0;
    tests++; if (if0.out_valid !== 1'b0 || if0.out !== 4'd0 || pend0 !== 16'h0 || ovf0 !== 1'b0) begin failed++; $display("FAIL rmid_fix got v=%b o=%0d p=%h f=%b exp 0 0 0000 0", if0.out_valid, if0.out, pend0, ovf0); end
    tests++; if (if1.out_valid !== 1'b0 || if1.out !== 4'd0 || pend1 !== 16'h0 || ovf1 !== 1'b0) begin failed++; $display("FAIL rmid_rr got v=%b o=%0d p=%h f=%b exp 0 0 0000 0", if1.out_valid, if1.out, pend1, ovf1); end
  endtask

  task automatic test_rr_order();
    logic [3:0] exp0 [2];
    logic [3:0] exp1 [2];
    exp0 = '{4'd0, 4'd3};
    exp1 = '{4'd3, 4'd0};
    en = 1'b1; req = 16'h0005; rdy = 1'b0;
    tick();
    en = 1'b0; req = '0;
    tick();
    tests++; if (if0.out !== 4'd0 || if1.out !== 4'd0 || if1.out_valid !== 1'b1) begin failed++; $display("FAIL rr_first got o0=%0d o1=%0d v1=%b exp 0 0 1", if0.out, if1.out, if1.out_valid); end
    rdy = 1'b1;
    tick();
    tests++; if (if0.out !== 4'd2 || if1.out !== 4'd2) begin failed++; $display("FAIL rr_second got o0=%0d o1=%0d exp 2 2", if0.out, if1.out); end
    en = 1'b1; req = 16'h0009; rdy = 1'b0;
    tick();
    en = 1'b0; req = '0; rdy = 1'b1;
    tests++; if (pend1 !== 16'h000D || if1.out !== 4'd2) begin failed++; $display("FAIL rr_merge got p=%h o=%0d exp 000d 2", pend1, if1.out); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (if0.out !== exp0[i] || if0.out_valid !== 1'b1) begin failed++; $display("FAIL rr_fix%0d got o=%0d v=%b exp o=%0d v=1", i, if0.out, if0.out_valid, exp0[i]); end
      tests++; if (if1.out !== exp1[i] || if1.out_valid !== 1'b1) begin failed++; $display("FAIL rr_rot%0d got o=%0d v=%b exp o=%0d v=1", i, if1.out, if1.out_valid, exp1[i]); end
    end
    tick();
    tests++; if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0 || pend1 !== 16'h0) begin failed++; $display("FAIL rr_end got v0=%b v1=%b p=%h exp 0 0 0000", if0.out_valid, if1.out_valid, pend1); end
    rdy = 1'b0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_zero_req();
    test_en_low();
    test_burst();
    test_set_over_clear();
    test_backpressure();
    test_reset_mid();
    test_rr_order();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
